decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage for the 5-stage core. It adds an N-entry instruction queue between fetch and decode and uses valid/ready handshakes on both sides instead of a single shared stall. It decodes RV32I, plus Zicsr and optional M-extension encodings, into a registered control bundle for execute. The block sits between `fetch` and `execute`, reads the regfile and CSR file combinationally for the queue head, and reports register usage to hazard.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `ENABLE_M`, 1: when 1, OP with funct7=0000001 decodes as MUL/DIV; when 0, it is illegal.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`, `in_ready`  in/out  1  fetch handshake.
- `pc_in`, `next_pc_in`, `instruction_in`  in  32 each  fetched entry.
- `invalidate`  in  1  flush queue and output register.
- `stall`  in  1  hazard hold; head must not advance.
- `uses_rs1`, `uses_rs2`  out  1  head reads rs1/rs2; 0 when queue empty.
- `rs1_address`, `rs2_address`  out  5  head instr[19:15], instr[24:20].
- `rs1_data`, `rs2_data`  in  32  regfile read data.
- `csr_address`  out  12  head instr[31:20].
- `csr_data`  in  32; `csr_readable`, `csr_writeable`  in  1.
- `out_valid`  out  1; `out_ready`  in  1: execute handshake.
- `pc_out`, `next_pc_out`, `rs1_data_out`, `rs2_data_out`, `csr_data_out`, `imm_data_out`  out  32.
- `ctrl_out`  out  `decode_ctrl_t`  control bundle: alu function/modifier, select a/b, cmp function, jump, branch, load/store, size, signed, write select, rd, csr addr/read/write/readable/writeable, mret, wfi, mul_div, ecause, exception.

## Operation
- Enqueue when `in_valid && in_ready`; `in_ready = !full`. There is no pass-through while full.
- Head issue condition: `!empty && !stall && (!out_valid || out_ready)`. On issue, the head is decoded, all outputs are registered, `out_valid` goes to 1, and the head is popped.
- If `out_valid && out_ready` with no issue, `out_valid` drops to 0.
- If `out_valid && !out_ready`, all outputs hold stable.
- Decode table:
  - Default bundle: ALU_OR, SEL_IMM/SEL_IMM, imm 0, WRITE_SEL_ALU, rd 0, all flags 0.
  - Immediates: U, J, I, S, B, and zero-extended CSR-immediate.
  - Illegal encodings raise `exception`=1 with `ecause`=2. These cover: bad JALR funct3, branch funct3 01x, load size 11 or LWU, store funct3[2] or size 11, bad shift funct7, bad OP funct7, FENCE funct3[2:1]≠0, unknown SYSTEM, and unknown opcode.
  - ECALL gives ecause 11; EBREAK gives ecause 3.
  - MRET and WFI require exact funct7 with rs1=rd=0, otherwise ecause 2.
  - CSRRW/CSRRWI: read only if rd≠0. CSRRS/C(I): write only if rs1 field≠0.
- M decode (`ENABLE_M`=1, OP, funct7=0000001): `mul_div`=1, alu function = funct3, rd written, SEL_REG/SEL_REG.
- `uses_rs1` = head non-empty and opcode ∈ {JALR, LOAD, OP-IMM, BRANCH, STORE, OP, CSRRW/S/C}. `uses_rs2` = head non-empty and opcode ∈ {BRANCH, STORE, OP}.
- `invalidate` empties the queue and clears `out_valid` at the next edge. An enqueue attempted in the same cycle is dropped, and it overrides a simultaneous issue.

## Timing
- Reset (asynchronous): queue empty, pointers 0, `out_valid` 0, every registered data output 0, `ctrl_out` all-zero. Hence `in_ready` 1 and `uses_rs*` 0.
- A reset asserted mid-operation discards all contents immediately.
- Latency: accept at edge t, then `out_valid` at edge t+1. Register read and decode happen on the combinational head in the cycle between.
- Throughput: 1 instruction per cycle sustained with `out_ready` 1 and `stall` 0.
- Simultaneous push and pop when not full: count is unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. The count is `$clog2(DEPTH+1)` bits.
- `stall` is sampled only for the issue decision; it never blocks enqueue.

## Structure
- Package `pipeline_pkg` holds:
  - `decode_ctrl_t`
  - ALU_* and ALU_SEL_* constants
  - WRITE_SEL_* constants
  - opcode constants
  - ECAUSE_ILLEGAL=2, ECAUSE_BREAK=3, ECAUSE_ECALL=11
- Sub-module `instr_queue` (parametrised by DEPTH and width 96) is a synchronous FIFO with a head-peek output. Decode logic and the output register live in `decode_queue`.

## Test plan
- Reset, then push ADDI x1,x0,5 (0x00500093) with `out_ready`=1 → one cycle later `out_valid`=1, imm 5, rd 1, ALU_ADD_SUB, `uses_rs1` was 1 at head.
- Push 5 instructions with DEPTH=4 and `out_ready`=0 → `in_ready` drops after the queue fills. Raising `out_ready` drains them in order with no loss or duplication.
- Queue holds 3 entries and `invalidate` is pulsed while `in_valid`=1 → `out_valid` 0 next cycle, queue empty, the pushed entry is dropped.
- MUL x3,x1,x2 (0x022081B3) → ENABLE_M=1 gives `mul_div`=1, function 000. ENABLE_M=0 gives exception 1, ecause 2.
- `stall`=1 for 3 cycles with the head LW → no issue and output held. Release gives the issue on the next edge with load 1, size 10, signed 1.
- ECALL (0x00000073) gives ecause 11. CSRRS x0,mstatus,x0 gives csr_read 1, csr_write 0. Opcode 0x7F gives exception with ecause 2.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared decode definitions for the fetch/decode/execute path.
// Holds the registered control bundle type, ALU/operand/write-back select
// encodings, RV32I major opcodes and exception cause codes.
package pipeline_pkg;

    localparam logic [2:0] ALU_ADD_SUB = 3'b000;
    localparam logic [2:0] ALU_SLL     = 3'b001;
    localparam logic [2:0] ALU_SLT     = 3'b010;
    localparam logic [2:0] ALU_SLTU    = 3'b011;
    localparam logic [2:0] ALU_XOR     = 3'b100;
    localparam logic [2:0] ALU_SRL_SRA = 3'b101;
    localparam logic [2:0] ALU_OR      = 3'b110;
    localparam logic [2:0] ALU_AND_CLR = 3'b111;

    localparam logic [1:0] ALU_SEL_REG = 2'd0;
    localparam logic [1:0] ALU_SEL_IMM = 2'd1;
    localparam logic [1:0] ALU_SEL_PC  = 2'd2;
    localparam logic [1:0] ALU_SEL_CSR = 2'd3;

    localparam logic [1:0] WRITE_SEL_ALU     = 2'd0;
    localparam logic [1:0] WRITE_SEL_CSR     = 2'd1;
    localparam logic [1:0] WRITE_SEL_LOAD    = 2'd2;
    localparam logic [1:0] WRITE_SEL_NEXT_PC = 2'd3;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [3:0] ECAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] ECAUSE_BREAK   = 4'd3;
    localparam logic [3:0] ECAUSE_ECALL   = 4'd11;

    typedef struct packed {
        logic [2:0]  alu_function;
        logic        alu_function_modifier;  // SUB / SRA / CSR clear (a & ~b)
        logic [1:0]  alu_select_a;
        logic [1:0]  alu_select_b;
        logic [2:0]  cmp_function;
        logic        jump;
        logic        branch;
        logic        load;
        logic        store;
        logic [1:0]  load_store_size;
        logic        load_signed;
        logic [1:0]  write_select;
        logic [4:0]  rd_address;
        logic [11:0] csr_address;
        logic        csr_read;
        logic        csr_write;
        logic        csr_readable;
        logic        csr_writeable;
        logic        mret;
        logic        wfi;
        logic        mul_div;
        logic [3:0]  ecause;
        logic        exception;
    } decode_ctrl_t;

    // Bundle every decode starts from: an ALU pass of a zero immediate, no side effects.
    function automatic decode_ctrl_t default_ctrl();
        decode_ctrl_t c;
        c              = '0;
        c.alu_function = ALU_OR;
        c.alu_select_a = ALU_SEL_IMM;
        c.alu_select_b = ALU_SEL_IMM;
        c.write_select = WRITE_SEL_ALU;
        return c;
    endfunction

endpackage

// File: rtl/instr_queue.sv
// instr_queue: single-clock FIFO with head peek.
// Ports: clk, reset_n (async, active-low), push/push_data, pop, flush
// (empties the queue, wins over push/pop), full, empty, head_data (entry at
// the read pointer, valid when !empty).
module instr_queue
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: queued RV32I/Zicsr/M decode stage between fetch and execute.
// Ports: clk, reset_n (async, active-low); fetch side in_valid/in_ready with
// pc_in, next_pc_in, instruction_in; invalidate (flush), stall (hold head);
// register/CSR read addresses and data for the queue head; uses_rs1/rs2 to
// hazard; execute side out_valid/out_ready with registered pc, operands,
// immediate and the decode_ctrl_t bundle.
module decode_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  pc_in,
    input  logic [31:0]  next_pc_in,
    input  logic [31:0]  instruction_in,
    input  logic         invalidate,
    input  logic         stall,
    output logic         uses_rs1,
    output logic         uses_rs2,
    output logic [4:0]   rs1_address,
    output logic [4:0]   rs2_address,
    input  logic [31:0]  rs1_data,
    input  logic [31:0]  rs2_data,
    output logic [11:0]  csr_address,
    input  logic [31:0]  csr_data,
    input  logic         csr_readable,
    input  logic         csr_writeable,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  pc_out,
    output logic [31:0]  next_pc_out,
    output logic [31:0]  rs1_data_out,
    output logic [31:0]  rs2_data_out,
    output logic [31:0]  csr_data_out,
    output logic [31:0]  imm_data_out,
    output decode_ctrl_t ctrl_out
);
    logic        q_full, q_empty, q_push, q_pop, issue;
    logic [95:0] head;
    logic [31:0] head_pc, head_next_pc, instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
    logic [1:0]  csr_src;
    logic        illegal;
    decode_ctrl_t dec;
    logic [31:0] dec_imm;

    assign in_ready = !q_full;
    assign issue    = !q_empty && !stall && (!out_valid || out_ready);
    // invalidate drops a same-cycle enqueue and cancels a same-cycle issue
    assign q_push   = in_valid && !q_full && !invalidate;
    assign q_pop    = issue && !invalidate;

    instr_queue #(.DEPTH(DEPTH), .WIDTH(96)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (q_push),
        .push_data ({pc_in, next_pc_in, instruction_in}),
        .pop       (q_pop),
        .flush     (invalidate),
        .full      (q_full),
        .empty     (q_empty),
        .head_data (head)
    );

    assign {head_pc, head_next_pc, instr} = head;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign funct7 = instr[31:25];

    assign rs1_address = instr[19:15];
    assign rs2_address = instr[24:20];
    assign csr_address = instr[31:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_z = {27'b0, instr[19:15]};

    // CSR source operand: rs1 register, or the zero-extended rs1 field for the I forms
    assign csr_src = funct3[2] ? ALU_SEL_IMM : ALU_SEL_REG;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (!q_empty) begin
            case (opcode)
                OPC_JALR, OPC_LOAD, OPC_OP_IMM: uses_rs1 = 1'b1;
                OPC_BRANCH, OPC_STORE, OPC_OP: begin
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                end
                OPC_SYSTEM: uses_rs1 = !funct3[2] && (funct3[1:0] != 2'b00);
                default: ;
            endcase
        end
    end

    always_comb begin
        dec     = default_ctrl();
        dec_imm = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.rd_address = rd;
                dec_imm        = imm_u;
            end
            OPC_AUIPC: begin
                dec.alu_function = ALU_ADD_SUB;
                dec.alu_select_a = ALU_SEL_PC;
                dec.rd_address   = rd;
                dec_imm          = imm_u;
            end
            OPC_JAL: begin
                dec.jump         = 1'b1;
                dec.alu_function = ALU_ADD_SUB;
                dec.alu_select_a = ALU_SEL_PC;
                dec.write_select = WRITE_SEL_NEXT_PC;
                dec.rd_address   = rd;
                dec_imm          = imm_j;
            end
            OPC_JALR: begin
                illegal          = (funct3 != 3'b000);
                dec.jump         = 1'b1;
                dec.alu_function = ALU_ADD_SUB;
                dec.alu_select_a = ALU_SEL_REG;
                dec.write_select = WRITE_SEL_NEXT_PC;
                dec.rd_address   = rd;
                dec_imm          = imm_i;
            end
            OPC_BRANCH: begin
                illegal          = (funct3[2:1] == 2'b01);
                dec.branch       = 1'b1;
                dec.cmp_function = funct3;
                dec.alu_function = ALU_ADD_SUB;
                dec.alu_select_a = ALU_SEL_PC;
                dec_imm          = imm_b;
            end
            OPC_LOAD: begin
                illegal             = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
                dec.load            = 1'b1;
                dec.load_store_size = funct3[1:0];
                dec.load_signed     = !funct3[2];
                dec.alu_function    = ALU_ADD_SUB;
                dec.alu_select_a    = ALU_SEL_REG;
                dec.write_select    = WRITE_SEL_LOAD;
                dec.rd_address      = rd;
                dec_imm             = imm_i;
            end
            OPC_STORE: begin
                illegal             = funct3[2] || (funct3[1:0] == 2'b11);
                dec.store           = 1'b1;
                dec.load_store_size = funct3[1:0];
                dec.alu_function    = ALU_ADD_SUB;
                dec.alu_select_a    = ALU_SEL_REG;
                dec_imm             = imm_s;
            end
            OPC_OP_IMM: begin
                dec.alu_function = funct3;
                dec.alu_select_a = ALU_SEL_REG;
                dec.rd_address   = rd;
                dec_imm          = imm_i;
                if (funct3 == ALU_SLL) begin
                    illegal = (funct7 != 7'b0000000);
                end else if (funct3 == ALU_SRL_SRA) begin
                    if (funct7 == 7'b0100000) begin
                        dec.alu_function_modifier = 1'b1;
                    end else begin
                        illegal = (funct7 != 7'b0000000);
                    end
                end
            end
            OPC_OP: begin
                dec.alu_select_a = ALU_SEL_REG;
                dec.alu_select_b = ALU_SEL_REG;
                dec.rd_address   = rd;
                dec.alu_function = funct3;
                if (funct7 == 7'b0000000) begin
                    dec.alu_function_modifier = 1'b0;
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == ALU_ADD_SUB || funct3 == ALU_SRL_SRA)) begin
                    dec.alu_function_modifier = 1'b1;
                end else if (ENABLE_M && funct7 == 7'b0000001) begin
                    dec.mul_div = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE / FENCE.I retire as no-ops in this in-order core
                illegal = (funct3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    if (rs1 != 5'd0 || rd != 5'd0) begin
                        illegal = 1'b1;
                    end else begin
                        case (instr[31:20])
                            12'h000: begin
                                dec.exception = 1'b1;
                                dec.ecause    = ECAUSE_ECALL;
                            end
                            12'h001: begin
                                dec.exception = 1'b1;
                                dec.ecause    = ECAUSE_BREAK;
                            end
                            12'h302: dec.mret = 1'b1;
                            12'h105: dec.wfi  = 1'b1;
                            default: illegal  = 1'b1;
                        endcase
                    end
                end else if (funct3 == 3'b100) begin
                    illegal = 1'b1;
                end else begin
                    dec.csr_address   = instr[31:20];
                    dec.csr_readable  = csr_readable;
                    dec.csr_writeable = csr_writeable;
                    dec.write_select  = WRITE_SEL_CSR;
                    dec.rd_address    = rd;
                    dec_imm           = imm_z;
                    if (funct3[1:0] == 2'b01) begin
                        // CSRRW: new value is the source itself (x | x)
                        dec.alu_function = ALU_OR;
                        dec.alu_select_a = csr_src;
                        dec.alu_select_b = csr_src;
                        dec.csr_read     = (rd != 5'd0);
                        dec.csr_write    = 1'b1;
                    end else begin
                        dec.alu_function          = funct3[0] ? ALU_AND_CLR : ALU_OR;
                        dec.alu_function_modifier = funct3[0];
                        dec.alu_select_a          = ALU_SEL_CSR;
                        dec.alu_select_b          = csr_src;
                        dec.csr_read              = 1'b1;
                        dec.csr_write             = (rs1 != 5'd0);
                    end
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec           = default_ctrl();
            dec_imm       = '0;
            dec.exception = 1'b1;
            dec.ecause    = ECAUSE_ILLEGAL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            pc_out       <= '0;
            next_pc_out  <= '0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            csr_data_out <= '0;
            imm_data_out <= '0;
            ctrl_out     <= '0;
        end else if (invalidate) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            pc_out       <= head_pc;
            next_pc_out  <= head_next_pc;
            rs1_data_out <= rs1_data;
            rs2_data_out <= rs2_data;
            csr_data_out <= csr_data;
            imm_data_out <= dec_imm;
            ctrl_out     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed bench for decode_queue (DEPTH=4) with one
// instance per ENABLE_M setting sharing the same stimulus.
module tb_decode_queue;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, invalidate, stall, out_ready;
    logic [31:0] pc_in, next_pc_in, instruction_in;
    logic [31:0] rs1_data, rs2_data, csr_data;
    logic        csr_readable, csr_writeable;

    logic        in_ready_m, uses_rs1_m, uses_rs2_m, out_valid_m;
    logic [4:0]  rs1_addr_m, rs2_addr_m;
    logic [11:0] csr_addr_m;
    logic [31:0] pc_out_m, npc_out_m, rs1_out_m, rs2_out_m, csr_out_m, imm_out_m;
    decode_ctrl_t ctrl_m;

    logic        in_ready_n, uses_rs1_n, uses_rs2_n, out_valid_n;
    logic [4:0]  rs1_addr_n, rs2_addr_n;
    logic [11:0] csr_addr_n;
    logic [31:0] pc_out_n, npc_out_n, rs1_out_n, rs2_out_n, csr_out_n, imm_out_n;
    decode_ctrl_t ctrl_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register file / CSR file stand-ins: data is a fixed tag plus the address.
    assign rs1_data = 32'h0000_1000 + {27'b0, rs1_addr_m};
    assign rs2_data = 32'h0000_2000 + {27'b0, rs2_addr_m};
    assign csr_data = 32'hC000_0000 | {20'b0, csr_addr_m};
    assign csr_readable  = 1'b1;
    assign csr_writeable = 1'b1;

    decode_queue #(.DEPTH(4), .ENABLE_M(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .instruction_in(instruction_in),
        .invalidate(invalidate), .stall(stall),
        .uses_rs1(uses_rs1_m), .uses_rs2(uses_rs2_m),
        .rs1_address(rs1_addr_m), .rs2_address(rs2_addr_m),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .csr_address(csr_addr_m), .csr_data(csr_data),
        .csr_readable(csr_readable), .csr_writeable(csr_writeable),
        .out_valid(out_valid_m), .out_ready(out_ready),
        .pc_out(pc_out_m), .next_pc_out(npc_out_m),
        .rs1_data_out(rs1_out_m), .rs2_data_out(rs2_out_m),
        .csr_data_out(csr_out_m), .imm_data_out(imm_out_m), .ctrl_out(ctrl_m)
    );

    decode_queue #(.DEPTH(4), .ENABLE_M(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .pc_in(pc_in), .next_pc_in(next_pc_in), .instruction_in(instruction_in),
        .invalidate(invalidate), .stall(stall),
        .uses_rs1(uses_rs1_n), .uses_rs2(uses_rs2_n),
        .rs1_address(rs1_addr_n), .rs2_address(rs2_addr_n),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .csr_address(csr_addr_n), .csr_data(csr_data),
        .csr_readable(csr_readable), .csr_writeable(csr_writeable),
        .out_valid(out_valid_n), .out_ready(out_ready),
        .pc_out(pc_out_n), .next_pc_out(npc_out_n),
        .rs1_data_out(rs1_out_n), .rs2_data_out(rs2_out_n),
        .csr_data_out(csr_out_n), .imm_data_out(imm_out_n), .ctrl_out(ctrl_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid       = v;
        instruction_in = instr;
        pc_in          = pc;
        next_pc_in     = pc + 32'd4;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        return {12'(k), 5'd0, 3'b000, 5'(k), 7'h13};
    endfunction

    initial begin
        reset_n    = 1'b0;
        out_ready  = 1'b0;
        stall      = 1'b0;
        invalidate = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        check("reset_out_valid", 32'(out_valid_m), 32'd0);
        check("reset_in_ready",  32'(in_ready_m),  32'd1);
        check("reset_uses_rs1",  32'(uses_rs1_m),  32'd0);
        check("reset_uses_rs2",  32'(uses_rs2_m),  32'd0);
        check("reset_ctrl_zero", 32'(|ctrl_m),     32'd0);
        check("reset_pc_out",    pc_out_m,         32'd0);
        step();
        step();
        reset_n = 1'b1;

        // ADDI x1,x0,5: accepted at one edge, issued on the next
        out_ready = 1'b1;
        drive(1'b1, 32'h0050_0093, 32'h0000_0100);
        check("addi_uses_rs1_empty", 32'(uses_rs1_m), 32'd0);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("addi_uses_rs1_head", 32'(uses_rs1_m),  32'd1);
        check("addi_not_yet_valid", 32'(out_valid_m), 32'd0);
        step();
        check("addi_out_valid", 32'(out_valid_m),           32'd1);
        check("addi_imm",       imm_out_m,                  32'd5);
        check("addi_rd",        32'(ctrl_m.rd_address),     32'd1);
        check("addi_alu_fn",    32'(ctrl_m.alu_function),   32'(ALU_ADD_SUB));
        check("addi_sel_a",     32'(ctrl_m.alu_select_a),   32'(ALU_SEL_REG));
        check("addi_sel_b",     32'(ctrl_m.alu_select_b),   32'(ALU_SEL_IMM));
        check("addi_pc",        pc_out_m,                   32'h0000_0100);
        check("addi_next_pc",   npc_out_m,                  32'h0000_0104);
        check("addi_rs1_data",  rs1_out_m,                  32'h0000_1000);
        step();
        check("addi_drained", 32'(out_valid_m), 32'd0);

        // Fill: one entry lands in the output register, four fill the queue,
        // the sixth is refused.
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, addi_k(k), 32'h200 + 32'(4 * k));
            check($sformatf("fill_in_ready_%0d", k), 32'(in_ready_m), (k <= 5) ? 32'd1 : 32'd0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        check("fill_hold_valid", 32'(out_valid_m), 32'd1);
        check("fill_hold_imm",   imm_out_m,        32'd1);
        check("fill_hold_pc",    pc_out_m,         32'h0000_0204);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check($sformatf("drain_valid_%0d", k), 32'(out_valid_m),       32'd1);
            check($sformatf("drain_imm_%0d", k),   imm_out_m,              32'(k));
            check($sformatf("drain_rd_%0d", k),    32'(ctrl_m.rd_address), 32'(k));
        end
        step();
        check("drain_done",     32'(out_valid_m), 32'd0);
        check("drain_in_ready", 32'(in_ready_m),  32'd1);

        // Invalidate with 3 queued entries, a valid output and a push attempt
        out_ready = 1'b0;
        for (int k = 7; k <= 10; k++) begin
            drive(1'b1, addi_k(k), 32'h300 + 32'(4 * k));
            step();
        end
        check("inv_pre_valid", 32'(out_valid_m), 32'd1);
        check("inv_pre_imm",   imm_out_m,        32'd7);
        check("inv_pre_head",  32'(uses_rs1_m),  32'd1);
        drive(1'b1, addi_k(11), 32'h400);
        invalidate = 1'b1;
        out_ready  = 1'b1;
        step();
        invalidate = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("inv_out_valid", 32'(out_valid_m), 32'd0);
        check("inv_empty",     32'(uses_rs1_m),  32'd0);
        check("inv_in_ready",  32'(in_ready_m),  32'd1);
        step();
        check("inv_push_dropped", 32'(out_valid_m), 32'd0);

        // MUL x3,x1,x2 under both ENABLE_M settings
        drive(1'b1, 32'h0220_81B3, 32'h500);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("mul_uses_rs2", 32'(uses_rs2_m), 32'd1);
        step();
        check("mul_valid",     32'(out_valid_m),         32'd1);
        check("mul_mul_div",   32'(ctrl_m.mul_div),      32'd1);
        check("mul_fn",        32'(ctrl_m.alu_function), 32'd0);
        check("mul_rd",        32'(ctrl_m.rd_address),   32'd3);
        check("mul_sel_b",     32'(ctrl_m.alu_select_b), 32'(ALU_SEL_REG));
        check("mul_exc",       32'(ctrl_m.exception),    32'd0);
        check("mul_rs1_data",  rs1_out_m,                32'h0000_1001);
        check("mul_rs2_data",  rs2_out_m,                32'h0000_2002);
        check("nom_exc",       32'(ctrl_n.exception),    32'd1);
        check("nom_ecause",    32'(ctrl_n.ecause),       32'(ECAUSE_ILLEGAL));
        check("nom_mul_div",   32'(ctrl_n.mul_div),      32'd0);

        // LW x5,8(x2) held by stall for three edges; enqueue still happens
        stall = 1'b1;
        drive(1'b1, 32'h0081_2283, 32'h600);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("lw_enqueued", 32'(uses_rs1_m), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_no_issue_%0d", i), 32'(out_valid_m), 32'd0);
            step();
        end
        check("stall_no_issue_3", 32'(out_valid_m), 32'd0);
        stall = 1'b0;
        step();
        check("lw_valid",    32'(out_valid_m),            32'd1);
        check("lw_load",     32'(ctrl_m.load),            32'd1);
        check("lw_size",     32'(ctrl_m.load_store_size), 32'd2);
        check("lw_signed",   32'(ctrl_m.load_signed),     32'd1);
        check("lw_wsel",     32'(ctrl_m.write_select),    32'(WRITE_SEL_LOAD));
        check("lw_rd",       32'(ctrl_m.rd_address),      32'd5);
        check("lw_imm",      imm_out_m,                   32'd8);
        check("lw_rs1_data", rs1_out_m,                   32'h0000_1002);

        // Back-to-back ECALL, CSRRS x0,mstatus,x0, opcode 0x7F
        drive(1'b1, 32'h0000_0073, 32'h700);
        step();
        drive(1'b1, 32'h3000_2073, 32'h704);
        step();
        check("ecall_exc",    32'(ctrl_m.exception), 32'd1);
        check("ecall_ecause", 32'(ctrl_m.ecause),    32'(ECAUSE_ECALL));
        drive(1'b1, 32'h0000_007F, 32'h708);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("csrrs_valid",    32'(out_valid_m),       32'd1);
        check("csrrs_read",     32'(ctrl_m.csr_read),   32'd1);
        check("csrrs_write",    32'(ctrl_m.csr_write),  32'd0);
        check("csrrs_addr",     32'(ctrl_m.csr_address), 32'h0000_0300);
        check("csrrs_exc",      32'(ctrl_m.exception),  32'd0);
        check("csrrs_csr_data", csr_out_m,              32'hC000_0300);
        step();
        check("bad_opc_valid",  32'(out_valid_m),       32'd1);
        check("bad_opc_exc",    32'(ctrl_m.exception),  32'd1);
        check("bad_opc_ecause", 32'(ctrl_m.ecause),     32'(ECAUSE_ILLEGAL));

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, addi_k(12), 32'h800);
        step();
        drive(1'b1, addi_k(13), 32'h804);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("mid_pre_valid", 32'(out_valid_m), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid",    32'(out_valid_m), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready_m),  32'd1);
        check("mid_rst_uses_rs1", 32'(uses_rs1_m),  32'd0);
        check("mid_rst_pc",       pc_out_m,         32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("mid_rst_stays_empty", 32'(out_valid_m), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
